io_input_arbiter: RTL and testbench
===================================

# io_input_arbiter

Shares the single byte-stream input source (`in_read`/`io_in`/`eof` port of the input device) between two requesters, e.g. two subleq cores or a core and a debug loader. Arbitrates round-robin and captures the current input word. It pulses the source's advance strobe exactly once per delivered word. Returns the word, with an end-of-stream flag, through a per-requester request/acknowledge handshake. Sits between the input device and the cores' memory-mapped input address decode.

## Interface

- `WIDTH`, default `` `WORD_SIZE ``: data word width.
- `clk`  in  1: clock, all state on rising edge.
- `areset`  in  1: asynchronous reset, active-low. Low clears all state immediately.
- `req`  in  2: per-requester read request. Level; held high until the matching `ack` bit pulses.
- `ack`  out  2: one-hot, one-cycle acknowledge to the granted requester.
- `rd_data`  out  WIDTH: delivered word; valid only while `ack` nonzero.
- `rd_eof`  out  1: source was at end-of-stream for this transaction; valid only while `ack` nonzero.
- `src_data`  in  WIDTH: current word from input source (`io_in`).
- `src_eof`  in  1: source end-of-stream; when high, `src_data` is invalid.
- `src_read`  out  1: advance strobe to source (`in_read`); consumed on the rising edge ending the cycle it is high.
- `busy`  out  1: high whenever state is not IDLE.

## Operation

- FSM states: IDLE, ACK, SETTLE. Reset state IDLE.
- IDLE: if `req` == 0, stay. Otherwise pick winner and go to ACK.
  - One request: the winner is that requester.
  - Both requesting: the winner is the requester not granted last.
- On the IDLE→ACK edge, registered:
  - `ack` <= one-hot(winner).
  - `rd_eof` <= `src_eof`.
  - `rd_data` <= `src_eof` ? EOF value : `src_data`.
  - `src_read` <= ~`src_eof`.
  - last-grant pointer <= winner.
- ACK: lasts exactly one cycle, then SETTLE. On leaving ACK: `ack`, `src_read` <= 0. `rd_data`/`rd_eof` hold their value but are don't-care.
- SETTLE: one cycle, lets the source present its next word. Always → IDLE. `req` is ignored in ACK and SETTLE.
- End-of-stream:
  - Every request is still acknowledged, with `rd_eof` = 1.
  - `src_read` is never asserted while `src_eof` is sampled high.
  - `src_eof` is not latched; it is re-sampled per transaction.
- Requesters must drop `req` no later than the cycle after `ack`. A `req` still high when IDLE is re-entered starts a new transaction.

## Timing

- Reset values: `ack` = 0, `rd_data` = 0, `rd_eof` = 0, `src_read` = 0, `busy` = 0, last-grant pointer = requester 1, so requester 0 wins the first contention.
- Latency: `req` high in IDLE during cycle T → `ack`, `rd_data`, `src_read` high during T+1.
- `busy` is high during T+1 and T+2. IDLE resumes at T+3.
- Back-to-back throughput: one word per 3 cycles. Minimum `ack`-to-`ack` spacing is 3 cycles.
- `src_read` is high for at most one cycle per transaction and only coincident with `ack`.
- Simultaneous `req` rising in the same cycle: exactly one `ack`. The other requester wins the next transaction if still requesting.
- `areset` low mid-transaction, including during ACK:
  - Outputs go to reset values asynchronously.
  - A `src_read` already sampled by the source is not undone.
  - The pending requester receives no `ack` and must re-request.

## Configuration

- `IO_ARB_EOF_NEG1_EN` defined: EOF value is all-ones, i.e. −1 in subleq arithmetic, so programs can detect EOF by sign.
- Undefined: EOF value is all-zeros. `rd_eof` behaviour is identical in both cases.

## Test plan

- Single request: `src_data` = 0x41, `src_eof` = 0, `req` = 01 in cycle T → `ack` = 01, `rd_data` = 0x41, `src_read` = 1 in T+1. `busy` is 1 in T+1..T+2 and 0 in T+3.
- Contention after reset: `req` = 11 held → `ack` sequence 01, 10, 01 at 3-cycle spacing. Three `src_read` pulses. The data words follow the source order.
- EOF: `src_eof` = 1, `req` = 10 → `ack` = 10, `rd_eof` = 1, `src_read` stays 0. `rd_data` = all-ones with `IO_ARB_EOF_NEG1_EN` defined, 0 without it.
- Last word then EOF: one byte 0x7A remaining → first transaction returns 0x7A with `rd_eof` = 0. The source then raises `eof`, and the second transaction returns `rd_eof` = 1 with no `src_read`.
- Reset during ACK: assert `areset` = 0 mid-cycle T+1 → `ack`, `src_read`, `busy` fall immediately. After release with `req` = 00, no `ack` occurs.
- `req` held through SETTLE: `req` = 01 held 5 cycles → `ack` in T+1 and T+4 only, never in SETTLE.

Source files
------------

// File: rtl/io_input_arbiter.sv
// io_input_arbiter: round-robin share of one byte-stream input source between
// two requesters. Captures the current source word on grant, pulses the source
// advance strobe once per delivered word, and returns word + end-of-stream flag
// through a per-requester req/ack handshake.
//
// Optional feature macro IO_ARB_EOF_NEG1_EN: when defined the word returned at
// end-of-stream is all-ones (-1 in subleq arithmetic); otherwise all-zeros.

`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module io_input_arbiter #(
  parameter int unsigned WIDTH = `WORD_SIZE
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [1:0]       req,
  output logic [1:0]       ack,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_eof,
  input  logic [WIDTH-1:0] src_data,
  input  logic             src_eof,
  output logic             src_read,
  output logic             busy
);

`ifdef IO_ARB_EOF_NEG1_EN
  localparam logic [WIDTH-1:0] EofValue = '1;
`else
  localparam logic [WIDTH-1:0] EofValue = '0;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StAck,
    StSettle
  } state_e;

  state_e state_q;
  logic   last_q;   // index of the requester granted most recently
  logic   winner;

  // Pick the winner: a lone requester wins, contention goes to the one not granted last.
  always_comb begin
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~last_q;
    end else begin
      winner = req[1];
    end
  end

  // Transaction FSM with registered handshake and source-strobe outputs.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      ack      <= 2'b00;
      rd_data  <= '0;
      rd_eof   <= 1'b0;
      src_read <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req != 2'b00) begin
            state_q  <= StAck;
            ack      <= winner ? 2'b10 : 2'b01;
            rd_eof   <= src_eof;
            rd_data  <= src_eof ? EofValue : src_data;
            // Never advance a source that has nothing left to give.
            src_read <= ~src_eof;
            last_q   <= winner;
          end
        end
        StAck: begin
          state_q  <= StSettle;
          ack      <= 2'b00;
          src_read <= 1'b0;
        end
        StSettle: begin
          // One idle-looking cycle so the source can present its next word.
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_io_input_arbiter.sv
// Testbench for io_input_arbiter: table-driven single transactions, hand-written
// multi-cycle sequences (contention, EOF, reset during ACK, held request) and a
// randomized phase checked against a timeline model of the arbiter.

module tb_io_input_arbiter;

  localparam int unsigned W = 8;
`ifdef IO_ARB_EOF_NEG1_EN
  localparam logic [W-1:0] EofV = '1;
`else
  localparam logic [W-1:0] EofV = '0;
`endif

  logic         clk = 1'b0;
  logic         areset = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [1:0]   ack;
  logic [W-1:0] rd_data;
  logic         rd_eof;
  logic [W-1:0] src_data = '0;
  logic         src_eof = 1'b0;
  logic         src_read;
  logic         busy;

  io_input_arbiter #(.WIDTH(W)) dut (
    .clk      (clk),
    .areset   (areset),
    .req      (req),
    .ack      (ack),
    .rd_data  (rd_data),
    .rd_eof   (rd_eof),
    .src_data (src_data),
    .src_eof  (src_eof),
    .src_read (src_read),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: timeline of when the arbiter is next free, plus last grant.
  int cyc = 0;
  int next_idle = 0;
  int last = 1;

  // Source model: bytes still to deliver; empty means end-of-stream.
  logic [W-1:0] srcq[$];
  bit use_q = 1'b0;

  int ack_count[2];
  int read_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic refresh_src();
    if (use_q) begin
      src_eof = (srcq.size() == 0);
      src_data = (srcq.size() != 0) ? srcq[0] : W'($urandom);
    end
  endtask

  // Advance one cycle: inputs as set now are what the next rising edge sees.
  // Outputs are compared at the following falling edge.
  task automatic tick();
    logic [1:0]   p_req;
    logic [W-1:0] p_d;
    logic         p_e;
    logic [1:0]   e_ack;
    logic         e_read;
    logic         e_eof;
    logic [W-1:0] e_data;
    int           win;
    p_req = req;
    p_d = src_data;
    p_e = src_eof;
    @(negedge clk);
    cyc++;
    e_ack = 2'b00;
    e_read = 1'b0;
    e_eof = 1'b0;
    e_data = '0;
    if ((cyc - 1) >= next_idle && p_req != 2'b00) begin
      if (p_req == 2'b11) win = 1 - last;
      else win = (p_req == 2'b10) ? 1 : 0;
      last = win;
      e_ack = 2'(1 << win);
      e_eof = p_e;
      e_data = p_e ? EofV : p_d;
      e_read = !p_e;
      next_idle = cyc + 2;
    end
    check("ack", 32'(ack), 32'(e_ack));
    check("src_read", 32'(src_read), 32'(e_read));
    check("busy", 32'(busy), 32'(cyc < next_idle));
    if (e_ack != 2'b00) begin
      check("rd_data", 32'(rd_data), 32'(e_data));
      check("rd_eof", 32'(rd_eof), 32'(e_eof));
    end
    if (ack[0]) ack_count[0]++;
    if (ack[1]) ack_count[1]++;
    if (src_read) begin
      read_count++;
      if (use_q && srcq.size() != 0) void'(srcq.pop_front());
    end
    refresh_src();
  endtask

  typedef struct {
    logic [1:0]   req;
    logic [W-1:0] data;
    logic         eof;
    logic [1:0]   e_ack;
    logic [W-1:0] e_data;
    logic         e_eof;
    logic         e_read;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // Expected grants assume the pointer starts at requester 1 after reset.
    vecs[0] = '{2'b01, 8'h41, 1'b0, 2'b01, 8'h41, 1'b0, 1'b1};
    vecs[1] = '{2'b10, 8'h55, 1'b0, 2'b10, 8'h55, 1'b0, 1'b1};
    vecs[2] = '{2'b11, 8'h12, 1'b0, 2'b01, 8'h12, 1'b0, 1'b1};
    vecs[3] = '{2'b11, 8'h34, 1'b0, 2'b10, 8'h34, 1'b0, 1'b1};
    vecs[4] = '{2'b10, 8'h99, 1'b1, 2'b10, EofV,  1'b1, 1'b0};
    vecs[5] = '{2'b01, 8'h7A, 1'b0, 2'b01, 8'h7A, 1'b0, 1'b1};
    vecs[6] = '{2'b11, 8'hC3, 1'b1, 2'b10, EofV,  1'b1, 1'b0};

    // Reset values while held in reset.
    #12;
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_rd_data", 32'(rd_data), 32'h0);
    check("rst_rd_eof", 32'(rd_eof), 32'h0);
    check("rst_src_read", 32'(src_read), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    areset = 1'b1;

    // Table-driven single transactions from IDLE.
    for (int i = 0; i < 7; i++) begin
      req = vecs[i].req;
      src_data = vecs[i].data;
      src_eof = vecs[i].eof;
      tick();
      check("tbl_ack", 32'(ack), 32'(vecs[i].e_ack));
      check("tbl_rd_data", 32'(rd_data), 32'(vecs[i].e_data));
      check("tbl_rd_eof", 32'(rd_eof), 32'(vecs[i].e_eof));
      check("tbl_src_read", 32'(src_read), 32'(vecs[i].e_read));
      check("tbl_busy_t1", 32'(busy), 32'h1);
      req = 2'b00;
      tick();
      check("tbl_busy_t2", 32'(busy), 32'h1);
      tick();
      check("tbl_busy_t3", 32'(busy), 32'h0);
    end

    // Contention with req=11 held: grants alternate, data follows source order.
    use_q = 1'b1;
    srcq = '{8'h10, 8'h20, 8'h30, 8'h40};
    refresh_src();
    ack_count[0] = 0;
    ack_count[1] = 0;
    read_count = 0;
    req = 2'b11;
    for (int i = 0; i < 9; i++) tick();
    req = 2'b00;
    tick();
    tick();
    // Pointer was at requester 1 after the last table entry: 01, 10, 01.
    check("cont_ack0", 32'(ack_count[0]), 32'd2);
    check("cont_ack1", 32'(ack_count[1]), 32'd1);
    check("cont_reads", 32'(read_count), 32'd3);
    check("cont_remaining", 32'(srcq.size()), 32'd1);

    // Last word then EOF: one read of 0x7A, then an EOF delivery with no read.
    srcq = '{8'h7A};
    refresh_src();
    read_count = 0;
    req = 2'b10;
    tick();
    check("last_data", 32'(rd_data), 32'h7A);
    check("last_eof", 32'(rd_eof), 32'h0);
    req = 2'b00;
    tick();
    tick();
    req = 2'b01;
    tick();
    check("eof_ack", 32'(ack), 32'h1);
    check("eof_flag", 32'(rd_eof), 32'h1);
    check("eof_data", 32'(rd_data), 32'(EofV));
    req = 2'b00;
    tick();
    tick();
    check("eof_reads", 32'(read_count), 32'd1);

    // req=01 held 5 cycles: acks in T+1 and T+4 only.
    srcq = '{8'h01, 8'h02, 8'h03};
    refresh_src();
    ack_count[0] = 0;
    req = 2'b01;
    for (int i = 0; i < 5; i++) tick();
    req = 2'b00;
    tick();
    tick();
    check("held_acks", 32'(ack_count[0]), 32'd2);

    // Reset during ACK: outputs fall at once, no ack after release.
    use_q = 1'b0;
    src_eof = 1'b0;
    src_data = 8'h5A;
    req = 2'b01;
    tick();
    check("rstack_pre_ack", 32'(ack), 32'h1);
    areset = 1'b0;
    #1;
    check("rstack_ack", 32'(ack), 32'h0);
    check("rstack_src_read", 32'(src_read), 32'h0);
    check("rstack_busy", 32'(busy), 32'h0);
    check("rstack_rd_data", 32'(rd_data), 32'h0);
    req = 2'b00;
    @(negedge clk);
    cyc++;
    areset = 1'b1;
    last = 1;
    next_idle = 0;
    for (int i = 0; i < 4; i++) tick();

    // Pointer was reset too: contention grants requester 0 first.
    req = 2'b11;
    tick();
    check("post_rst_grant", 32'(ack), 32'h1);
    req = 2'b00;
    tick();
    tick();

    // Randomized traffic: requesters drop req the cycle after their ack.
    use_q = 1'b1;
    srcq.delete();
    refresh_src();
    for (int i = 0; i < 600; i++) begin
      tick();
      for (int r = 0; r < 2; r++) begin
        if (ack[r]) req[r] = 1'b0;
        else if (!req[r] && $urandom_range(0, 2) == 0) req[r] = 1'b1;
      end
      if (srcq.size() < 3 && $urandom_range(0, 3) != 0) begin
        srcq.push_back(W'($urandom));
        refresh_src();
      end
    end
    req = 2'b00;
    tick();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
